// File: rtl/mem_io_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : mem_io_unit
//  Purpose  : MEM/WB load path and memory-mapped IO for the 3-stage RISC-V
//             core. Registers MEM-stage load information into WB, aligns and
//             extends load data, owns the cycle/instruction counters and the
//             UART ready/valid handshakes.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_io_unit #(
   parameter logic [31:0] IO_BASE   = 32'h8000_0000,
   parameter int          CNT_WIDTH = 32,
   parameter int          UART_W    = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [31:0]          inst_mem,
   input  logic                 inst_valid,
   input  logic [31:0]          addr,
   input  logic [31:0]          store_data,
   input  logic [31:0]          dmem_dout,
   input  logic [UART_W-1:0]    uart_rx_data,
   input  logic                 uart_rx_valid,
   output logic                 uart_rx_ready,
   output logic [UART_W-1:0]    uart_tx_data,
   output logic                 uart_tx_valid,
   input  logic                 uart_tx_ready,
   output logic [31:0]          ld_data,
   output logic [CNT_WIDTH-1:0] cycle_count,
   output logic [CNT_WIDTH-1:0] inst_count
);

   localparam logic [6:0] OP_LOAD  = 7'b000_0011;
   localparam logic [6:0] OP_STORE = 7'b010_0011;

   // IO registers are decoded on word granularity (addr[4:2])
   localparam logic [2:0] REG_CTRL = 3'd0;
   localparam logic [2:0] REG_RXD  = 3'd1;
   localparam logic [2:0] REG_TXD  = 3'd2;
   localparam logic [2:0] REG_CYC  = 3'd4;
   localparam logic [2:0] REG_INST = 3'd5;
   localparam logic [2:0] REG_CRST = 3'd6;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;

   // ------------------------------------------------------------------------
   // MEM-stage decode
   // ------------------------------------------------------------------------
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       is_load_op;
   logic       is_store_op;
   logic       retire;
   logic       load_fire;
   logic       store_fire;
   logic       io_hit;
   logic [2:0] reg_sel;
   logic       tx_write;
   logic       cnt_clear;
   logic       unused_bits;

   assign opcode      = inst_mem[6:0];
   assign funct3      = inst_mem[14:12];
   assign is_load_op  = (opcode == OP_LOAD);
   assign is_store_op = (opcode == OP_STORE);
   assign retire      = !stall && inst_valid;
   assign load_fire   = retire && is_load_op;
   assign store_fire  = retire && is_store_op;
   assign io_hit      = (addr[31:5] == IO_BASE[31:5]);
   assign reg_sel     = addr[4:2];
   assign tx_write    = store_fire && io_hit && (reg_sel == REG_TXD);
   assign cnt_clear   = store_fire && io_hit && (reg_sel == REG_CRST);

   // Instruction/data bits that this unit never looks at
   assign unused_bits = ^{inst_mem[31:15], inst_mem[11:7], store_data};

   // Rx byte is consumed only when a rx-data load actually fires with data present
   assign uart_rx_ready = !rst && load_fire && io_hit && (reg_sel == REG_RXD) && uart_rx_valid;

   // ------------------------------------------------------------------------
   // IO read word, sampled in MEM so WB sees the value as of that edge
   // ------------------------------------------------------------------------
   logic [31:0] io_word;
   logic [31:0] rx_word;
   logic [31:0] cyc_word;
   logic [31:0] inst_word;

   // Zero-extend narrow sources to 32 bits and select the addressed IO register
   always_comb begin
      rx_word                     = '0;
      rx_word[UART_W-1:0]         = uart_rx_data;
      cyc_word                    = '0;
      cyc_word[CNT_WIDTH-1:0]     = cycle_count;
      inst_word                   = '0;
      inst_word[CNT_WIDTH-1:0]    = inst_count;
      io_word                     = '0;
      case (reg_sel)
         REG_CTRL: io_word = {30'd0, uart_rx_valid, !uart_tx_valid};
         REG_RXD:  io_word = uart_rx_valid ? rx_word : 32'd0;
         REG_CYC:  io_word = cyc_word;
         REG_INST: io_word = inst_word;
         default:  io_word = '0;
      endcase
   end

   // ------------------------------------------------------------------------
   // MEM -> WB register
   // ------------------------------------------------------------------------
   logic        wb_load;
   logic        wb_io;
   logic [2:0]  wb_funct3;
   logic [1:0]  wb_lo;
   logic [31:0] wb_word;

   // Advance on every non-stalled edge; a stall holds the load in WB
   always_ff @(posedge clk) begin
      if (rst) begin
         wb_load   <= 1'b0;
         wb_io     <= 1'b0;
         wb_funct3 <= '0;
         wb_lo     <= '0;
         wb_word   <= '0;
      end else if (!stall) begin
         wb_load   <= inst_valid && is_load_op;
         wb_io     <= io_hit;
         wb_funct3 <= funct3;
         wb_lo     <= addr[1:0];
         wb_word   <= io_word;
      end
   end

   // ------------------------------------------------------------------------
   // WB load alignment and extension
   // ------------------------------------------------------------------------
   logic [31:0] ld_src;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;

   // Pick IO or memory word, then extract and extend the addressed lane
   always_comb begin
      ld_src  = wb_io ? wb_word : dmem_dout;
      ld_half = wb_lo[1] ? ld_src[31:16] : ld_src[15:0];
      case (wb_lo)
         2'd0:    ld_byte = ld_src[7:0];
         2'd1:    ld_byte = ld_src[15:8];
         2'd2:    ld_byte = ld_src[23:16];
         default: ld_byte = ld_src[31:24];
      endcase
      ld_data = '0;
      if (wb_load) begin
         case (wb_funct3)
            F3_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            F3_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            F3_LW:   ld_data = ld_src;
            F3_LBU:  ld_data = {24'd0, ld_byte};
            F3_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = '0;
         endcase
      end
   end

   // ------------------------------------------------------------------------
   // UART transmit holding register
   // ------------------------------------------------------------------------
   // Completing handshake has priority; stores while a byte is pending are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         uart_tx_valid <= 1'b0;
         uart_tx_data  <= '0;
      end else if (uart_tx_valid && uart_tx_ready) begin
         uart_tx_valid <= 1'b0;
      end else if (tx_write && !uart_tx_valid) begin
         uart_tx_valid <= 1'b1;
         uart_tx_data  <= store_data[UART_W-1:0];
      end
   end

   // ------------------------------------------------------------------------
   // Cycle and retired-instruction counters
   // ------------------------------------------------------------------------
   // Counter-reset store wins over the same-cycle increments
   always_ff @(posedge clk) begin
      if (rst) begin
         cycle_count <= '0;
         inst_count  <= '0;
      end else if (cnt_clear) begin
         cycle_count <= '0;
         inst_count  <= '0;
      end else begin
         cycle_count <= cycle_count + CNT_WIDTH'(1);
         if (retire) begin
            inst_count <= inst_count + CNT_WIDTH'(1);
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_io_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_mem_io_unit
//  Purpose  : Self-checking bench for mem_io_unit: directed scenarios with
//             literal expectations, then randomized traffic against a
//             transaction-level model. Two instances share stimulus, one
//             with 32-bit and one with 4-bit counters.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_io_unit;

   localparam logic [31:0] IO_BASE = 32'h8000_0000;
   localparam logic [6:0]  LD  = 7'h03;
   localparam logic [6:0]  ST  = 7'h23;
   localparam logic [6:0]  ALU = 7'h13;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, stall, inst_valid, rx_valid, tx_ready;
   logic [31:0] inst_mem, addr, store_data, dmem_dout;
   logic [7:0]  rx_data;

   logic        rx_ready_a, tx_valid_a, rx_ready_b, tx_valid_b;
   logic [7:0]  tx_data_a, tx_data_b;
   logic [31:0] ld_a, ld_b, cyc_a, icnt_a;
   logic [3:0]  cyc_b, icnt_b;

   mem_io_unit #(.IO_BASE(IO_BASE), .CNT_WIDTH(32), .UART_W(8)) dut_a (
      .clk(clk), .rst(rst), .stall(stall), .inst_mem(inst_mem), .inst_valid(inst_valid),
      .addr(addr), .store_data(store_data), .dmem_dout(dmem_dout),
      .uart_rx_data(rx_data), .uart_rx_valid(rx_valid), .uart_rx_ready(rx_ready_a),
      .uart_tx_data(tx_data_a), .uart_tx_valid(tx_valid_a), .uart_tx_ready(tx_ready),
      .ld_data(ld_a), .cycle_count(cyc_a), .inst_count(icnt_a)
   );

   mem_io_unit #(.IO_BASE(IO_BASE), .CNT_WIDTH(4), .UART_W(8)) dut_b (
      .clk(clk), .rst(rst), .stall(stall), .inst_mem(inst_mem), .inst_valid(inst_valid),
      .addr(addr), .store_data(store_data), .dmem_dout(dmem_dout),
      .uart_rx_data(rx_data), .uart_rx_valid(rx_valid), .uart_rx_ready(rx_ready_b),
      .uart_tx_data(tx_data_b), .uart_tx_valid(tx_valid_b), .uart_tx_ready(tx_ready),
      .ld_data(ld_b), .cycle_count(cyc_b), .inst_count(icnt_b)
   );

   int total = 0;
   int bad   = 0;
   int pulses = 0;

   // ---------------- reference model state ----------------
   int unsigned m_cyc, m_icnt;
   bit          m_txv;
   logic [7:0]  m_txd;
   bit          m_wb_load, m_wb_io;
   logic [2:0]  m_wb_f3;
   logic [1:0]  m_wb_lo;
   logic [31:0] m_wb_word_a, m_wb_word_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Architectural load result for a given word, funct3 and byte offset
   function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] lo);
      logic [31:0] sb, sh;
      sb = w >> (8 * int'(lo));
      sh = w >> (lo[1] ? 16 : 0);
      case (f3)
         3'd0:    return {{24{sb[7]}}, sb[7:0]};
         3'd1:    return {{16{sh[15]}}, sh[15:0]};
         3'd2:    return w;
         3'd4:    return {24'd0, sb[7:0]};
         3'd5:    return {16'd0, sh[15:0]};
         default: return 32'd0;
      endcase
   endfunction

   // What an IO load of register 'sel' returns right now
   function automatic logic [31:0] io_read(input logic [2:0] sel, input int unsigned mask);
      case (sel)
         3'd0:    return {30'd0, rx_valid, !m_txv};
         3'd1:    return rx_valid ? {24'd0, rx_data} : 32'd0;
         3'd4:    return m_cyc & mask;
         3'd5:    return m_icnt & mask;
         default: return 32'd0;
      endcase
   endfunction

   // Advance the model by one clock edge using the inputs presented before it
   task automatic model_step();
      bit is_ld, is_st, fire, io;
      logic [2:0] sel;
      if (rst) begin
         m_cyc = 0; m_icnt = 0; m_txv = 0; m_txd = '0;
         m_wb_load = 0; m_wb_io = 0; m_wb_f3 = '0; m_wb_lo = '0;
         m_wb_word_a = '0; m_wb_word_b = '0;
      end else begin
         is_ld = (inst_mem[6:0] == LD);
         is_st = (inst_mem[6:0] == ST);
         fire  = !stall && inst_valid && (is_ld || is_st);
         io    = (addr[31:5] == IO_BASE[31:5]);
         sel   = addr[4:2];
         if (!stall) begin
            m_wb_load   = inst_valid && is_ld;
            m_wb_io     = io;
            m_wb_f3     = inst_mem[14:12];
            m_wb_lo     = addr[1:0];
            m_wb_word_a = io_read(sel, 32'hFFFF_FFFF);
            m_wb_word_b = io_read(sel, 32'h0000_000F);
         end
         if (m_txv && tx_ready) m_txv = 0;
         else if (!m_txv && fire && is_st && io && sel == 3'd2) begin
            m_txv = 1;
            m_txd = store_data[7:0];
         end
         if (fire && is_st && io && sel == 3'd6) begin
            m_cyc = 0; m_icnt = 0;
         end else begin
            m_cyc++;
            if (!stall && inst_valid) m_icnt++;
         end
      end
   endtask

   // Compare every DUT output with the model
   task automatic compare();
      logic exp_rx;
      logic [31:0] exp_a, exp_b;
      exp_rx = !rst && !stall && inst_valid && (inst_mem[6:0] == LD) &&
               (addr[31:5] == IO_BASE[31:5]) && (addr[4:2] == 3'd1) && rx_valid;
      exp_a = m_wb_load ? extract(m_wb_io ? m_wb_word_a : dmem_dout, m_wb_f3, m_wb_lo) : 32'd0;
      exp_b = m_wb_load ? extract(m_wb_io ? m_wb_word_b : dmem_dout, m_wb_f3, m_wb_lo) : 32'd0;
      if (rx_ready_a) pulses++;
      check("rx_ready_a", {31'd0, rx_ready_a}, {31'd0, exp_rx});
      check("rx_ready_b", {31'd0, rx_ready_b}, {31'd0, exp_rx});
      check("tx_valid_a", {31'd0, tx_valid_a}, {31'd0, m_txv});
      check("tx_valid_b", {31'd0, tx_valid_b}, {31'd0, m_txv});
      check("tx_data_a", {24'd0, tx_data_a}, {24'd0, m_txd});
      check("ld_data_a", ld_a, exp_a);
      check("ld_data_b", ld_b, exp_b);
      check("cycle_a", cyc_a, m_cyc);
      check("inst_a", icnt_a, m_icnt);
      check("cycle_b", {28'd0, cyc_b}, m_cyc & 32'hF);
      check("inst_b", {28'd0, icnt_b}, m_icnt & 32'hF);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      @(negedge clk);
      compare();
   endtask

   task automatic drive(input logic v, input logic [6:0] op, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] sd);
      inst_valid = v;
      inst_mem   = {17'd0, f3, 5'd0, op};
      addr       = a;
      store_data = sd;
   endtask

   task automatic idle();
      drive(1'b0, ALU, 3'd0, 32'd0, 32'd0);
   endtask

   initial begin
      logic [2:0] ld_f3 [5];
      int r;
      ld_f3[0] = 3'd0; ld_f3[1] = 3'd1; ld_f3[2] = 3'd2; ld_f3[3] = 3'd4; ld_f3[4] = 3'd5;

      rst = 1'b1; stall = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
      dmem_dout = '0;
      idle();
      tick(); tick();
      check("reset_cycle", cyc_a, 32'd0);
      check("reset_ld", ld_a, 32'd0);
      check("reset_txv", {31'd0, tx_valid_a}, 32'd0);

      rst = 1'b0;
      repeat (10) tick();
      check("idle10_cycle", cyc_a, 32'd10);
      check("idle10_inst", icnt_a, 32'd0);
      check("idle10_cycle4", {28'd0, cyc_b}, 32'd10);

      // load alignment from data memory
      dmem_dout = 32'h8001_FF7F;
      drive(1'b1, LD, 3'd0, 32'h0000_1001, 32'd0); tick();
      check("lb", ld_a, 32'hFFFF_FFFF);
      drive(1'b1, LD, 3'd4, 32'h0000_1001, 32'd0); tick();
      check("lbu", ld_a, 32'h0000_00FF);
      drive(1'b1, LD, 3'd1, 32'h0000_1002, 32'd0); tick();
      check("lh", ld_a, 32'hFFFF_8001);
      drive(1'b1, LD, 3'd2, 32'h0000_1001, 32'd0); tick();
      check("lw", ld_a, 32'h8001_FF7F);

      // rx read held by a stall still consumes once
      rx_valid = 1'b1; rx_data = 8'hA5; pulses = 0;
      stall = 1'b1;
      drive(1'b1, LD, 3'd2, IO_BASE + 32'h4, 32'd0);
      repeat (3) tick();
      stall = 1'b0; tick();
      check("rx_lw", ld_a, 32'h0000_00A5);
      idle(); tick();
      check("rx_pulses", pulses, 32'd1);
      rx_valid = 1'b0;

      // tx store, dropped second store, handshake, ctrl read
      drive(1'b1, ST, 3'd2, IO_BASE + 32'h8, 32'h1234_5642); tick();
      check("tx_set", {31'd0, tx_valid_a}, 32'd1);
      check("tx_byte", {24'd0, tx_data_a}, 32'h42);
      drive(1'b1, ST, 3'd2, IO_BASE + 32'h8, 32'h0000_0099); tick();
      check("tx_drop", {24'd0, tx_data_a}, 32'h42);
      idle(); tx_ready = 1'b1; tick();
      check("tx_done", {31'd0, tx_valid_a}, 32'd0);
      tx_ready = 1'b0;
      drive(1'b1, LD, 3'd2, IO_BASE, 32'd0); tick();
      check("ctrl", ld_a, 32'd1);

      // counter reset then read inst_count one instruction later
      drive(1'b1, ALU, 3'd0, 32'd0, 32'd0);
      repeat (5) tick();
      drive(1'b1, ST, 3'd2, IO_BASE + 32'h18, 32'hDEAD_BEEF); tick();
      check("crst_inst", icnt_a, 32'd0);
      check("crst_cycle", cyc_a, 32'd0);
      drive(1'b1, ALU, 3'd0, 32'd0, 32'd0); tick();
      drive(1'b1, LD, 3'd2, IO_BASE + 32'h14, 32'd0); tick();
      check("inst_read", ld_a, 32'd1);

      // 4-bit counter wrap and zero-extended readback
      idle();
      repeat (13) tick();
      check("cyc4_15", {28'd0, cyc_b}, 32'd15);
      drive(1'b1, LD, 3'd2, IO_BASE + 32'h10, 32'd0); tick();
      check("cyc4_wrap", {28'd0, cyc_b}, 32'd0);
      check("cyc4_read", ld_b, 32'h0000_000F);
      check("cyc32_read", ld_a, 32'd15);

      // randomized traffic
      repeat (3000) begin
         rst        = ($urandom_range(0, 199) == 0);
         stall      = ($urandom_range(0, 3) == 0);
         rx_valid   = ($urandom_range(0, 1) == 0);
         rx_data    = 8'($urandom);
         tx_ready   = ($urandom_range(0, 2) == 0);
         dmem_dout  = $urandom;
         inst_valid = ($urandom_range(0, 9) < 7);
         r = int'($urandom_range(0, 9));
         if (r < 4)      inst_mem = {17'd0, ld_f3[$urandom_range(0, 4)], 5'd0, LD};
         else if (r < 7) inst_mem = {17'd0, 3'd2, 5'd0, ST};
         else            inst_mem = {17'd0, 3'd0, 5'd0, ALU};
         if ($urandom_range(0, 1) == 0)
            addr = IO_BASE | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
         else
            addr = $urandom & 32'h7FFF_FFFF;
         store_data = $urandom;
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/mem_io_unit.md
Name: mem_io_unit

Overview:
- Memory/writeback-stage load and memory-mapped-IO unit for the 3-stage RISC-V core.
- Replaces the purely combinational MEM-stage load decode.
- Registers MEM-stage load info into WB and returns aligned, sign/zero-extended load data.
- Owns the cycle and instruction counters and the UART ready/valid handshakes, with side-effecting IO accesses taken exactly once per instruction.

Parameters:
- IO_BASE, 32'h80000000, base of the IO region.
- CNT_WIDTH, 32, width of the cycle/instruction counters (1..32); readback is zero-extended to 32.
- UART_W, 8, UART data width.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- stall  in  1  pipeline hold; MEM→WB register and all side effects frozen
- inst_mem  in  32  MEM-stage instruction (opcode, funct3)
- inst_valid  in  1  MEM-stage instruction is real (not a bubble); retires at this edge when !stall
- addr  in  32  MEM-stage ALU result (effective address)
- store_data  in  32  MEM-stage rs2 value
- dmem_dout  in  32  data-memory read word, valid in WB (sync-read BRAM)
- uart_rx_data  in  UART_W  received byte
- uart_rx_valid  in  1  rx byte available
- uart_rx_ready  out  1  rx byte consumed
- uart_tx_data  out  UART_W  byte to transmit
- uart_tx_valid  out  1  tx byte pending
- uart_tx_ready  in  1  transmitter accepts byte
- ld_data  out  32  WB-stage load result
- cycle_count  out  CNT_WIDTH  free-running cycle counter
- inst_count  out  CNT_WIDTH  retired-instruction counter

Behaviour:
- All outputs reset to 0 on rst; the WB register also clears to "no load" (ld_data = 0).
- IO map, as offsets from IO_BASE:
  - +0x00 UART ctrl (R): {0…, rx_valid, tx_ready_eff}, where tx_ready_eff = !uart_tx_valid.
  - +0x04 UART rx data (R).
  - +0x08 UART tx data (W).
  - +0x10 cycle_count (R).
  - +0x14 inst_count (R).
  - +0x18 counter reset (W, data ignored).
  - Any other IO_BASE address reads 0 and ignores writes.
  - An address is IO iff addr[31:5] == IO_BASE[31:5].
- An access "fires" when !stall && inst_valid && opcode is LOAD or STORE.
- MEM→WB register, captured on fire or on any non-stalled edge:
  - Captures funct3, addr[1:0], is_load, io_hit, io_word.
  - io_word is sampled in MEM: rx byte, ctrl, or counter value at that edge.
  - When stall=1 the register holds.
- ld_data is combinational from the WB register: source = io_hit ? io_word : dmem_dout.
  - LW: word; addr[1:0] ignored.
  - LH/LHU: half selected by addr[1]; sign/zero-extended.
  - LB/LBU: byte selected by addr[1:0]; sign/zero-extended.
  - Not a load: 0.
  - Latency is 1 cycle from the MEM edge.
- RX: uart_rx_ready pulses high for exactly the MEM cycle in which a rx-data load fires, gated by uart_rx_valid.
  - Reading when rx_valid = 0 returns 0 and produces no pulse.
- TX: a store to +0x08 when uart_tx_valid = 0 latches store_data[UART_W-1:0] and sets uart_tx_valid next cycle.
  - uart_tx_valid stays high, with data stable, until a cycle with uart_tx_ready = 1; it clears on that edge.
  - A store while uart_tx_valid = 1 is dropped; held data is unchanged.
  - A store and a handshake completing in the same cycle: the handshake clears, the store is dropped.
- cycle_count: +1 every non-reset cycle, including stalls; wraps 2^CNT_WIDTH−1 → 0.
- inst_count: +1 on each edge with !stall && inst_valid; wraps.
- Counter-reset store: both counters read 0 after that edge, overriding the same-cycle increment. The store itself is not counted.
- Stall: no rx pulse, no tx latch, no counter reset, no inst_count increment. IO side effects happen exactly once even if the instruction sits in MEM for several cycles.
- rst mid-operation, including with a pending tx: everything clears next edge and the pending byte is lost.

Test Plan:
- rst = 1 for 2 cycles → all outputs 0. Release, 10 cycles, no valid instructions → cycle_count = 10, inst_count = 0.
- dmem_dout = 32'h8001_FF7F, addr[1:0] = 1:
  - LB → ld_data = 32'hFFFF_FFFF.
  - LBU → 32'h0000_00FF.
  - LH with addr[1:0] = 2 → 32'hFFFF_8001.
  - LW → 32'h8001_FF7F.
- rx_valid = 1, rx_data = 8'hA5, LW from 0x80000004 → uart_rx_ready high exactly 1 cycle, ld_data = 32'hA5. Same load held by stall = 1 for 3 cycles → still one pulse.
- SW 32'h1234_5642 to 0x80000008 with tx_ready = 0 → tx_valid = 1, tx_data = 8'h42. A second SW of 8'h99 is dropped. tx_ready = 1 → tx_valid = 0 next cycle. Ctrl read then returns bit0 = 1.
- 5 retired instructions, then SW to 0x80000018 → next cycle inst_count = 0, cycle_count = 0. LW from 0x80000014 one instruction later → ld_data = 1.
- CNT_WIDTH = 4, 16 cycles → cycle_count wraps 15 → 0. LW from 0x80000010 reads a zero-extended value.
